// File: rtl/syn_arb_pkg.sv
// Shared types and sizing constants for the din-lane arbiters.
package syn_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester after i_ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_onehot,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    always_comb begin
        int                   w_c;
        logic [$clog2(N)-1:0] w_cidx;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_c      = 0;
        w_cidx   = '0;
        // k runs 1..N so the pointer's own slot is searched last
        for (int k = 1; k <= N; k++) begin
            w_c    = (int'(i_ptr) + k) % N;
            w_cidx = w_c[$clog2(N)-1:0];
            if (!o_any && i_valid[w_cidx]) begin
                o_any            = 1'b1;
                o_onehot[w_cidx] = 1'b1;
                o_idx            = w_cidx;
            end
        end
    end

endmodule

// File: rtl/syn_din_arb.sv
// Round-robin arbiter sharing the din lane; each granted word is held HOLD_CYCLES clocks.
// Define SYN_DIN_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module syn_din_arb
    import syn_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DW          = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DW-1:0]            din,
    output logic                     din_valid,
`ifdef SYN_DIN_ARB_STATS_EN
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_REQ*STAT_W-1:0]  grant_cnt
`else
    output logic [$clog2(N_REQ)-1:0] grant_id
`endif
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     w_idx;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_any;
    logic              w_window;
    logic              w_xfer;
    logic [DW-1:0]     r_din;
    logic              r_din_valid;
    logic [IW-1:0]     r_grant_id;

    rr_pick #(.N(N_REQ)) u_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_state_nxt = HOLD;
            HOLD:    if (r_cnt == '0 && !w_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ready is forced low during reset even though the pick sees live valids
    always_comb begin
        w_window  = (r_state == IDLE) || (r_cnt == '0);
        req_ready = '0;
        if (w_window && !rst) req_ready = w_onehot;
        w_xfer    = w_window && w_any && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ptr       <= IW'(N_REQ - 1);
            r_din       <= '0;
            r_din_valid <= 1'b0;
            r_grant_id  <= '0;
        end else if (w_xfer) begin
            r_cnt       <= HOLD_W'(HOLD_CYCLES - 1);
            r_ptr       <= w_idx;
            r_din       <= req_data[int'(w_idx)*DW +: DW];
            r_din_valid <= 1'b1;
            r_grant_id  <= w_idx;
        end else if (r_state == HOLD) begin
            if (r_cnt != '0) r_cnt       <= r_cnt - 1'b1;
            else             r_din_valid <= 1'b0;
        end
    end

    assign din       = r_din;
    assign din_valid = r_din_valid;
    assign grant_id  = r_grant_id;

`ifdef SYN_DIN_ARB_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [N_REQ-1:0][STAT_W-1:0] r_stat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= '0;
        end else if (w_xfer) begin
            for (int i = 0; i < N_REQ; i++)
                if (w_onehot[i]) r_stat[i] <= sat_inc(r_stat[i]);
        end
    end

    assign grant_cnt = r_stat;
`endif

endmodule

// File: doc/syn_din_arb.md
Name: syn_din_arb

Overview:
- Round-robin arbiter that shares the 4-bit din input lane of syn_top between N_REQ independent stimulus sources.
- Each source offers a DW-bit word with a valid/ready handshake.
- The winner's word is registered onto din and held for HOLD_CYCLES clocks before the next grant.
- Sits between the bench/stimulus generators and syn_top din_0..din_3.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 4, data width of each request and of din.
- HOLD_CYCLES, 2, clocks each granted word stays on din (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester offer.
- req_data  input  N_REQ*DW  requester i occupies bits [i*DW +: DW].
- req_ready  output  N_REQ  one-hot-or-zero accept strobe.
- din  output  DW  registered word driven to syn_top din_0..din_3.
- din_valid  output  1  high while din carries a granted word.
- grant_id  output  $clog2(N_REQ)  index of the requester currently on din.

Behaviour:
- Reset, asynchronous while rst=1:
  - din=0, din_valid=0, grant_id=0.
  - State IDLE, hold counter=0.
  - Priority pointer=N_REQ-1, so requester 0 wins first.
- States:
  - IDLE: nothing on din.
  - HOLD: word on din, counter running.
- Accept window is open in IDLE, or in HOLD when counter==0.
- Winner: first i with req_valid[i]=1, searching from pointer+1 and wrapping modulo N_REQ.
- req_ready:
  - Combinational.
  - Only the winner's bit is high, and only while the accept window is open.
  - All zero if no valid.
  - req_ready never depends on req_data.
- Transfer happens on the clock edge where req_ready[i] & req_valid[i]. At that edge:
  - din<=req_data[i], din_valid<=1, grant_id<=i.
  - pointer<=i, counter<=HOLD_CYCLES-1.
  - state<=HOLD.
- HOLD with counter>0: counter decrements; din, grant_id and din_valid are unchanged.
- HOLD with counter==0:
  - If a winner exists, a new transfer occurs (back-to-back, no bubble).
  - Otherwise state<=IDLE and din_valid<=0. din keeps the last value; grant_id keeps the last index.
- Latency:
  - Word appears on din 1 clock after acceptance.
  - Sustained throughput is one word per HOLD_CYCLES clocks.
- HOLD_CYCLES=1 gives a new word every clock under continuous requests.
- A requester dropping valid before being granted is legal and is not latched.
- A requester keeping valid high after its grant competes again at lowest priority.
- Reset mid-HOLD aborts the grant immediately; the pending word is lost.
- Single requester with continuous valid: granted every HOLD_CYCLES clocks.

Optional Feature:
- Macro: SYN_DIN_ARB_STATS_EN.
- With the macro:
  - Extra output port grant_cnt, width N_REQ*16, one 16-bit counter per requester.
  - Each counter increments on every transfer of that requester and saturates at 16'hFFFF.
  - Counters reset to 0 on rst.
- Without the macro: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package syn_arb_pkg holds:
  - State enum arb_state_t {IDLE, HOLD}.
  - localparam STAT_W=16.
  - localparam HOLD_W=8.
- Sub-module rr_pick: purely combinational. Inputs are the valid vector and the pointer; outputs are winner one-hot, winner index and any_valid. It is reused by later arbiters.
- The top holds the FSM, counter, din/grant registers and optional stats.

Test Plan:
- Reset defaults: assert rst for 3 clocks with all req_valid=1 -> din=0, din_valid=0, grant_id=0, req_ready=0 while in reset.
- Full round-robin: all four valid, data 4'h1,4'h2,4'h3,4'h4, HOLD_CYCLES=2 -> din sequence 1,1,2,2,3,3,4,4,1,1; grant_id 0,0,1,1,2,2,3,3,0,0; no bubbles.
- Single requester 2, data 4'hA, continuous valid, HOLD_CYCLES=1 -> din=4'hA every clock from the cycle after the first accept; req_ready[2] high every clock.
- Idle gap: requester 1 offers 4'h5 for one accepted transfer, then all valid low -> din_valid high for exactly HOLD_CYCLES clocks, then 0; din stays 4'h5.
- Reset mid-HOLD: rst pulse while din=4'h7, counter=1 -> din=0 and din_valid=0 asynchronously; next grant goes to requester 0 if valid.
- Stats (macro on): 300 accepted transfers from requester 3 -> grant_cnt[3]=300, others 0; force 70000 transfers -> saturates at 16'hFFFF.
